pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / trap controller
//
// Turns per-stage stall requests into a cumulative hold vector, handles trap
// redirects by flushing the pipeline for FLUSH_CYCLES cycles, and keeps a
// stall watchdog plus a stall performance counter.
//
// Parameters:
//   FLUSH_CYCLES   flush length per trap, including the trap cycle (1..15)
//   STALL_TIMEOUT  continuous stalled cycles before the watchdog fires (1..65535)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   stallreq_if_i    fetch stage stall request
//   stallreq_id_i    decode stage stall request
//   stallreq_ex_i    execute stage stall request
//   stallreq_mem_i   memory stage stall request
//   trap_req_i       trap taken, flush and redirect
//   trap_pc_i        trap handler address, valid with trap_req_i
//   stall_o          per-stage hold {wb, mem, ex, id, if, pc}, comb
//   flush_o          flush all pipeline registers, comb
//   new_pc_o         redirect address, comb
//   new_pc_valid_o   one-cycle redirect strobe, comb
//   stall_timeout_o  sticky watchdog flag, registered
//   stall_cnt_o      count of stalled cycles (wraps), registered
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cnt_o
);

  // Flush cycles still owed after the trap cycle itself.
  localparam logic [3:0]  FlushReload = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WdLimit     = 16'(STALL_TIMEOUT);
  localparam bit          MultiFlush  = (FLUSH_CYCLES > 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_flush_cnt;
  logic [3:0]  w_flush_cnt_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [15:0] r_wd;
  logic [15:0] w_wd_next;
  logic        r_timeout;
  logic        w_timeout_next;
  logic [31:0] r_stall_cnt;
  logic [31:0] w_stall_cnt_next;
  logic [5:0]  w_stall_mask;
  logic        w_stalling;

  // Highest requesting stage wins; every stage upstream of it holds too.
  always_comb begin
    w_stall_mask = 6'b000000;
    if (stallreq_mem_i) begin
      w_stall_mask = 6'b011111;
    end else if (stallreq_ex_i) begin
      w_stall_mask = 6'b001111;
    end else if (stallreq_id_i) begin
      w_stall_mask = 6'b000111;
    end else if (stallreq_if_i) begin
      w_stall_mask = 6'b000011;
    end
  end

  // Next-state and combinational outputs.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_pc_next        = r_pc;
    stall_o          = 6'b000000;
    flush_o          = 1'b0;
    new_pc_o         = r_pc;
    new_pc_valid_o   = 1'b0;

    if (rst_i) begin
      // Outputs quiet while in reset; the register block clears state.
      w_state_next     = StRun;
      w_flush_cnt_next = 4'd0;
    end else if (trap_req_i) begin
      // A trap (re)starts a full-length flush from any state.
      flush_o        = 1'b1;
      new_pc_o       = trap_pc_i;
      new_pc_valid_o = 1'b1;
      w_pc_next      = trap_pc_i;
      if (MultiFlush) begin
        w_state_next     = StFlush;
        w_flush_cnt_next = FlushReload;
      end else begin
        w_state_next     = StRun;
        w_flush_cnt_next = 4'd0;
      end
    end else begin
      unique case (r_state)
        StRun: begin
          stall_o = w_stall_mask;
        end
        StFlush: begin
          flush_o = 1'b1;
          if (r_flush_cnt <= 4'd1) begin
            w_state_next     = StRun;
            w_flush_cnt_next = 4'd0;
          end else begin
            w_flush_cnt_next = r_flush_cnt - 4'd1;
          end
        end
        default: begin
          w_state_next     = StRun;
          w_flush_cnt_next = 4'd0;
        end
      endcase
    end
  end

  // stall_o is already zero in reset, trap and flush cycles, so those never count.
  assign w_stalling = |stall_o;

  // Watchdog saturates at the limit; the flag is raised on the edge that
  // completes the STALL_TIMEOUT-th consecutive stalled cycle.
  always_comb begin
    w_wd_next        = r_wd;
    w_timeout_next   = r_timeout;
    w_stall_cnt_next = r_stall_cnt;
    if (w_stalling) begin
      w_stall_cnt_next = r_stall_cnt + 32'd1;
      if (r_wd < WdLimit) begin
        w_wd_next = r_wd + 16'd1;
      end
      if (r_wd >= WdLimit - 16'd1) begin
        w_timeout_next = 1'b1;
      end
    end else begin
      w_wd_next = 16'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StRun;
      r_flush_cnt <= 4'd0;
      r_pc        <= 32'h0000_0000;
      r_wd        <= 16'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_pc        <= w_pc_next;
      r_wd        <= w_wd_next;
      r_timeout   <= w_timeout_next;
      r_stall_cnt <= w_stall_cnt_next;
    end
  end

  assign stall_timeout_o = r_timeout;
  assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int FC = 3;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_if = 1'b0, s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] tpc = 32'h0;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        timeout;
  logic [31:0] stall_cnt;

  pipe_ctrl #(
    .FLUSH_CYCLES (FC),
    .STALL_TIMEOUT(TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stallreq_if_i  (s_if),
    .stallreq_id_i  (s_id),
    .stallreq_ex_i  (s_ex),
    .stallreq_mem_i (s_mem),
    .trap_req_i     (trap),
    .trap_pc_i      (tpc),
    .stall_o        (stall),
    .flush_o        (flush),
    .new_pc_o       (new_pc),
    .new_pc_valid_o (new_pc_valid),
    .stall_timeout_o(timeout),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        valid;
    logic        timeout;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference model: flush cycles still owed, latched pc, length of the
  // current stall run, sticky flag and stall cycle total.
  int          m_flush_left = 0;
  logic [31:0] m_pc = 32'h0;
  int          m_run = 0;
  bit          m_to = 1'b0;
  logic [31:0] m_cnt = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the edge, push the expected outputs.
  task automatic step(input bit r, input logic [3:0] req, input bit t, input logic [31:0] pc);
    exp_t e;
    int   top;
    @(posedge clk);
    #1;
    rst = r;
    {s_mem, s_ex, s_id, s_if} = req;
    trap = t;
    tpc  = pc;
    e.timeout = m_to;
    e.cnt     = m_cnt;
    e.new_pc  = m_pc;
    e.stall   = 6'd0;
    e.flush   = 1'b0;
    e.valid   = 1'b0;
    if (r) begin
      m_flush_left = 0;
      m_pc         = 32'h0;
      m_run        = 0;
      m_to         = 1'b0;
      m_cnt        = 32'h0;
    end else begin
      if (t) begin
        e.flush      = 1'b1;
        e.valid      = 1'b1;
        e.new_pc     = pc;
        m_pc         = pc;
        m_flush_left = FC - 1;
      end else if (m_flush_left > 0) begin
        e.flush = 1'b1;
        m_flush_left--;
      end else begin
        top = 0;
        for (int k = 0; k < 4; k++) if (req[k]) top = k + 1;
        if (top > 0) e.stall = 6'((1 << (top + 1)) - 1);
      end
      if (e.stall != 6'd0) begin
        m_cnt = m_cnt + 32'd1;
        if (m_run < TO) m_run++;
        if (m_run >= TO) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    q.push_back(e);
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("stall_o", 32'(stall), 32'(me.stall));
      chk("flush_o", 32'(flush), 32'(me.flush));
      chk("new_pc_o", new_pc, me.new_pc);
      chk("new_pc_valid_o", 32'(new_pc_valid), 32'(me.valid));
      chk("stall_timeout_o", 32'(timeout), 32'(me.timeout));
      chk("stall_cnt_o", stall_cnt, me.cnt);
    end
  end

  initial begin
    logic [3:0]  rq;
    bit          rr;
    bit          rt;
    logic [31:0] rpc;

    repeat (2) step(1, 4'b0000, 0, 32'h0);
    // Decode stall, then memory stall on top of it.
    repeat (3) step(0, 4'b0010, 0, 32'h0);
    repeat (3) step(0, 4'b1010, 0, 32'h0);
    step(0, 4'b0000, 0, 32'h0);
    // Single trap, full flush length.
    step(0, 4'b0000, 1, 32'h0000_0100);
    repeat (4) step(0, 4'b0000, 0, 32'h0);
    // Trap beats an execute stall; stall requests ignored while flushing.
    step(0, 4'b0100, 1, 32'h0000_0180);
    repeat (3) step(0, 4'b0100, 0, 32'h0);
    step(0, 4'b0000, 0, 32'h0);
    // Second trap in flush cycle 2 restarts the flush.
    step(0, 4'b0000, 1, 32'h0000_0100);
    step(0, 4'b0000, 1, 32'h0000_0200);
    repeat (4) step(0, 4'b0000, 0, 32'h0);
    // Watchdog: 7-cycle run stays quiet, 8-cycle run fires and sticks.
    repeat (7) step(0, 4'b0001, 0, 32'h0);
    step(0, 4'b0000, 0, 32'h0);
    repeat (8) step(0, 4'b0001, 0, 32'h0);
    repeat (3) step(0, 4'b0000, 0, 32'h0);
    // Reset in flush cycle 2 aborts the flush.
    step(0, 4'b0000, 1, 32'h0000_0300);
    step(1, 4'b1111, 1, 32'h0000_0400);
    repeat (3) step(0, 4'b0000, 0, 32'h0);
    // Randomized traffic.
    repeat (3000) begin
      rr  = ($urandom_range(0, 149) == 0);
      rq  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      rt  = ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      step(rr, rq, rt, rpc);
    end
    step(0, 4'b0000, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
